clk_ce_rst_gen: RTL and testbench
=================================

Name: clk_ce_rst_gen

Overview:
- Sits directly downstream of the system PLL.
- Runs on the 48 MHz system clock and consumes the PLL `locked` flag (asynchronous) plus a user reset request.
- Produces three things:
  - a debounced, stretched core reset;
  - a 6 MHz pixel clock-enable;
  - 6809-style quadrature E/Q strobes and levels at 1 MHz for the CPU and sound logic.
- All downstream logic runs on the single 48 MHz clock, gated by these enables.

Parameters:
- LOCK_STABLE, 1024, consecutive cycles the synchronized `locked` must stay high before reset release begins.
- RST_HOLD, 256, cycles the core reset stays asserted after lock is stable or after a user reset request.
- DIV_PIX, 8, clk_sys cycles per ce_pix pulse (48/8 = 6 MHz); must be ≥2.
- DIV_CPU, 48, clk_sys cycles per E/Q period (1 MHz); must be a multiple of 4 and ≥8.

Ports:
- clk_sys  in  1  48 MHz system clock, from PLL outclk_0.
- rst_n  in  1  synchronous active-low block reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk_sys.
- user_rst  in  1  synchronous user/OSD reset request, active high, level.
- core_rst_n  out  1  core reset, active low, registered.
- ce_pix  out  1  one-cycle pixel enable pulse.
- cpu_e  out  1  E level.
- cpu_q  out  1  Q level; leads E by a quarter period.
- ce_e_rise  out  1  one-cycle pulse on the cycle cpu_e goes 0→1.
- ce_e_fall  out  1  one-cycle pulse on the cycle cpu_e goes 1→0.
- ce_q_rise  out  1  one-cycle pulse on the cycle cpu_q goes 0→1.
- running  out  1  high in RUN state.

Behaviour:
- **Clocking and reset**
  - Single clock domain.
  - rst_n=0 sampled on a clk_sys edge gives:
    - state=WAIT_LOCK;
    - sync FFs=0, counters=0;
    - core_rst_n=0, running=0;
    - all ce_*=0, cpu_e=0, cpu_q=0.
- **Lock synchronizer**
  - pll_locked passes through a 2-FF synchronizer; lk_s is the second stage.
  - Synchronizer latency is 2 cycles.
- **FSM: WAIT_LOCK**
  - core_rst_n=0, lock counter cleared.
  - lk_s=1 → STABLE.
- **FSM: STABLE**
  - Lock counter increments each cycle while lk_s=1.
  - lk_s=0 → WAIT_LOCK, counter cleared.
  - Counter reaching LOCK_STABLE-1 → HOLD, hold counter cleared.
- **FSM: HOLD**
  - core_rst_n=0.
  - Hold counter increments each cycle.
  - At RST_HOLD-1 → RUN.
  - user_rst=1 clears the hold counter and stays in HOLD.
- **FSM: RUN**
  - core_rst_n=1, running=1.
  - user_rst=1 → HOLD with hold counter cleared; core_rst_n=0 from the next cycle.
- **Loss of lock**
  - In any state other than WAIT_LOCK, lk_s=0 → WAIT_LOCK next cycle.
  - Loss of lock takes priority over user_rst.
- **Enable generation**
  - Divider counters run only in RUN; they are held at 0 otherwise.
  - All ce_* outputs are forced 0 and cpu_e, cpu_q are forced 0 outside RUN.
  - pix_cnt counts 0..DIV_PIX-1 and wraps. ce_pix=1 when pix_cnt==DIV_PIX-1, so the first pulse comes DIV_PIX cycles after entering RUN.
  - cpu_cnt counts 0..DIV_CPU-1 and wraps. With P=DIV_CPU/4, the event points are:
    - cpu_cnt==P-1 → ce_q_rise; cpu_q←1.
    - cpu_cnt==2P-1 → ce_e_rise; cpu_e←1.
    - cpu_cnt==3P-1 → cpu_q←0.
    - cpu_cnt==4P-1 → ce_e_fall; cpu_e←0.
  - Pulses are registered coincident with the level change: the pulse and the new level are visible in the same cycle.
- **Ordering guarantees**
  - Exactly one pulse of each kind per period; no pulses on the RUN entry cycle.
  - On leaving RUN, all outputs drop in the same cycle core_rst_n drops.
- **Parameter checks**: counter widths come from $clog2 of the respective parameter; illegal parameters are a synthesis-time error.

Decomposition:
- Shared package clk_gen_pkg holds:
  - the state enum (WAIT_LOCK, STABLE, HOLD, RUN);
  - default constants for the four parameters;
  - a width function.
- One sub-module, sync2 (2-FF synchronizer, synchronous active-low reset to 0), used for pll_locked.
- Dividers and FSM stay in the top module.

Test Plan:
- Power-up:
  - Stimulus: rst_n low 4 cycles, then high; pll_locked rises at cycle 10 and stays high.
  - Response: core_rst_n stays 0 and rises at cycle 10+2+1024+256 (±1, per the FSM entry cycle); running rises the same cycle.
- Lock glitch:
  - Stimulus: pll_locked high 500 cycles, low 3 cycles, then high.
  - Response: the lock counter restarts, and core_rst_n release is delayed by a full LOCK_STABLE+RST_HOLD after the second rise.
- Enable cadence in RUN:
  - ce_pix pulses every 8 cycles.
  - ce_q_rise at cpu_cnt 11, ce_e_rise at 23, cpu_q fall at 35, ce_e_fall at 47.
  - E/Q duty 50%; 1000 periods checked with no missing or duplicate pulses.
- User reset:
  - Stimulus: user_rst held 5 cycles during RUN.
  - Response: core_rst_n=0 and all ce_*=0 from the next cycle; release 256 cycles after user_rst deasserts; the first ce_pix comes 8 cycles after release.
- Lock loss during HOLD while user_rst=1:
  - Response: state goes to WAIT_LOCK; outputs stay in reset.
- Mid-run rst_n:
  - Stimulus: rst_n=0 for 1 cycle during RUN.
  - Response: all outputs at their reset values on the next edge, then a full lock/hold sequence follows.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared state encodings, default divider/reset constants and counter width helper
// for the PLL-downstream clock-enable / reset generator.
package clk_gen_pkg;
    typedef logic [1:0] state_t;

    localparam state_t WAIT_LOCK = 2'd0;
    localparam state_t STABLE    = 2'd1;
    localparam state_t HOLD      = 2'd2;
    localparam state_t RUN       = 2'd3;

    localparam int LOCK_STABLE_DEF = 1024;
    localparam int RST_HOLD_DEF    = 256;
    localparam int DIV_PIX_DEF     = 8;
    localparam int DIV_CPU_DEF     = 48;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; q is the second stage.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/clk_ce_rst_gen.sv
// Lock-qualified core reset sequencer plus pixel and 6809 E/Q enable generation,
// all on the single system clock.
module clk_ce_rst_gen
    import clk_gen_pkg::*;
#(
    parameter int LOCK_STABLE = LOCK_STABLE_DEF,
    parameter int RST_HOLD    = RST_HOLD_DEF,
    parameter int DIV_PIX     = DIV_PIX_DEF,
    parameter int DIV_CPU     = DIV_CPU_DEF
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic user_rst,
    output logic core_rst_n,
    output logic ce_pix,
    output logic cpu_e,
    output logic cpu_q,
    output logic ce_e_rise,
    output logic ce_e_fall,
    output logic ce_q_rise,
    output logic running
);
    localparam int LW = cnt_w(LOCK_STABLE);
    localparam int HW = cnt_w(RST_HOLD);
    localparam int PW = cnt_w(DIV_PIX);
    localparam int CW = cnt_w(DIV_CPU);
    localparam int P  = DIV_CPU / 4;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(DIV_PIX - 1);
    localparam logic [CW-1:0] Q_RISE    = CW'(P - 1);
    localparam logic [CW-1:0] E_RISE    = CW'(2 * P - 1);
    localparam logic [CW-1:0] Q_FALL    = CW'(3 * P - 1);
    localparam logic [CW-1:0] E_FALL    = CW'(4 * P - 1);

    if (LOCK_STABLE < 1 || RST_HOLD < 1)
        $error("clk_ce_rst_gen: LOCK_STABLE and RST_HOLD must be >= 1");
    if (DIV_PIX < 2)
        $error("clk_ce_rst_gen: DIV_PIX must be >= 2");
    if (DIV_CPU < 8 || (DIV_CPU % 4) != 0)
        $error("clk_ce_rst_gen: DIV_CPU must be a multiple of 4 and >= 8");

    logic          lk_s;
    state_t        state, state_nx;
    logic [LW-1:0] lock_cnt, lock_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [PW-1:0] pix_cnt, pix_nx;
    logic [CW-1:0] cpu_cnt, cpu_nx;
    logic          keep;

    sync2 u_lk_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Loss of lock overrides everything, including a pending user reset.
    always_comb begin
        state_nx = state;
        lock_nx  = lock_cnt;
        hold_nx  = hold_cnt;
        if (state != WAIT_LOCK && !lk_s) begin
            state_nx = WAIT_LOCK;
            lock_nx  = '0;
            hold_nx  = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    lock_nx = '0;
                    if (lk_s) state_nx = STABLE;
                end
                STABLE: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end else begin
                        lock_nx = lock_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (user_rst)                   hold_nx  = '0;
                    else if (hold_cnt == HOLD_LAST) state_nx = RUN;
                    else                            hold_nx  = hold_cnt + 1'b1;
                end
                RUN: begin
                    if (user_rst) begin
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end
                end
                default: state_nx = WAIT_LOCK;
            endcase
        end
    end

    // Dividers advance only while staying in RUN; the entry cycle sits at count 0.
    assign keep   = (state == RUN) && (state_nx == RUN);
    assign pix_nx = !keep ? '0 : (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
    assign cpu_nx = !keep ? '0 : (cpu_cnt == E_FALL)   ? '0 : cpu_cnt + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            lock_cnt   <= '0;
            hold_cnt   <= '0;
            pix_cnt    <= '0;
            cpu_cnt    <= '0;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            ce_pix     <= 1'b0;
            cpu_e      <= 1'b0;
            cpu_q      <= 1'b0;
            ce_e_rise  <= 1'b0;
            ce_e_fall  <= 1'b0;
            ce_q_rise  <= 1'b0;
        end else begin
            state      <= state_nx;
            lock_cnt   <= lock_nx;
            hold_cnt   <= hold_nx;
            pix_cnt    <= pix_nx;
            cpu_cnt    <= cpu_nx;
            core_rst_n <= (state_nx == RUN);
            running    <= (state_nx == RUN);
            // Pulses are decoded from the next count so they land with the level change.
            ce_pix     <= keep && (pix_nx == PIX_LAST);
            ce_q_rise  <= keep && (cpu_nx == Q_RISE);
            ce_e_rise  <= keep && (cpu_nx == E_RISE);
            ce_e_fall  <= keep && (cpu_nx == E_FALL);
            cpu_q      <= !keep ? 1'b0 : (cpu_nx == Q_RISE) ? 1'b1 : (cpu_nx == Q_FALL) ? 1'b0 : cpu_q;
            cpu_e      <= !keep ? 1'b0 : (cpu_nx == E_RISE) ? 1'b1 : (cpu_nx == E_FALL) ? 1'b0 : cpu_e;
        end
    end
endmodule

// File: tb/tb_clk_ce_rst_gen.sv
// Directed bench for clk_ce_rst_gen at default parameters: reset sequencing,
// lock glitches, user reset and E/Q/pixel enable cadence.
module tb_clk_ce_rst_gen;
    logic clk_sys    = 1'b0;
    logic rst_n      = 1'b0;
    logic pll_locked = 1'b0;
    logic user_rst   = 1'b0;
    logic core_rst_n, ce_pix, cpu_e, cpu_q, ce_e_rise, ce_e_fall, ce_q_rise, running;
    logic [7:0] outs;

    int nvec = 0;
    int nerr = 0;
    int k;
    logic leak;

    clk_ce_rst_gen dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .user_rst   (user_rst),
        .core_rst_n (core_rst_n),
        .ce_pix     (ce_pix),
        .cpu_e      (cpu_e),
        .cpu_q      (cpu_q),
        .ce_e_rise  (ce_e_rise),
        .ce_e_fall  (ce_e_fall),
        .ce_q_rise  (ce_q_rise),
        .running    (running)
    );

    always #5 clk_sys = ~clk_sys;

    assign outs = {core_rst_n, running, ce_pix, cpu_e, cpu_q, ce_e_rise, ce_e_fall, ce_q_rise};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            if (nerr <= 20) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Counts negedges until core_rst_n is seen high; flags any output activity meanwhile.
    task automatic wait_rel(output int n, output logic lk, input int max);
        n  = 0;
        lk = 1'b0;
        do begin
            @(negedge clk_sys);
            n++;
            if (!core_rst_n && outs != 8'd0) lk = 1'b1;
        end while (!core_rst_n && n < max);
    endtask

    // Entered on the first RUN cycle (offset 0); checks every cycle against the ideal waveform.
    task automatic run_cadence(input int ncyc);
        int c, npix, nqr, ner, nef;
        logic [5:0] got, exp;
        npix = 0; nqr = 0; ner = 0; nef = 0;
        for (int i = 0; i < ncyc; i++) begin
            c   = i % 48;
            got = {ce_pix, cpu_e, cpu_q, ce_e_rise, ce_e_fall, ce_q_rise};
            exp = {(i % 8) == 7, (c >= 23 && c <= 46), (c >= 11 && c <= 34),
                   c == 23, c == 47, c == 11};
            chk("cadence", got, exp);
            npix += int'(ce_pix);
            nqr  += int'(ce_q_rise);
            ner  += int'(ce_e_rise);
            nef  += int'(ce_e_fall);
            @(negedge clk_sys);
        end
        chk("n_ce_pix", npix, ncyc / 8);
        chk("n_q_rise", nqr, ncyc / 48);
        chk("n_e_rise", ner, ncyc / 48);
        chk("n_e_fall", nef, ncyc / 48);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-up: lock rise -> 2 sync + 1024 stable + 256 hold + 1 entry cycle
        cyc(4);
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        cyc(6);
        chk("prelock_outs", outs, 0);
        pll_locked = 1'b1;
        wait_rel(k, leak, 3000);
        chk("powerup_release", k, 1283);
        chk("powerup_running", running, 1);
        chk("powerup_leak", leak, 0);
        chk("entry_no_pulse", outs[5:0], 0);

        run_cadence(48000);

        // user reset held 5 cycles; release 256 cycles after it drops
        user_rst = 1'b1;
        cyc(1);
        chk("usr_assert_outs", outs, 0);
        cyc(4);
        user_rst = 1'b0;
        wait_rel(k, leak, 1000);
        chk("usr_release", k, 256);
        chk("usr_leak", leak, 0);
        // counting the release cycle as the first RUN cycle, ce_pix is in the eighth
        k = 0;
        while (!ce_pix && k < 50) begin
            @(negedge clk_sys);
            k++;
        end
        chk("usr_first_pix", k, 7);

        // one-cycle rst_n during RUN, then a full lock/hold sequence
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_outs", outs, 0);
        rst_n = 1'b1;
        wait_rel(k, leak, 3000);
        chk("midrst_release", k, 1283);
        chk("midrst_leak", leak, 0);

        // lock loss in RUN: lk_s falls after two edges, outputs drop on the third
        cyc(20);
        pll_locked = 1'b0;
        cyc(2);
        chk("lol_still_run", core_rst_n, 1);
        cyc(1);
        chk("lol_outs", outs, 0);

        // lock glitch: 500 high, 3 low, then the full sequence restarts
        cyc(10);
        pll_locked = 1'b1;
        cyc(500);
        chk("glitch_pre_outs", outs, 0);
        pll_locked = 1'b0;
        cyc(3);
        pll_locked = 1'b1;
        wait_rel(k, leak, 3000);
        chk("glitch_release", k, 1283);
        chk("glitch_leak", leak, 0);

        // lock loss in HOLD with user_rst held must fall back to WAIT_LOCK
        cyc(20);
        user_rst = 1'b1;
        cyc(3);
        chk("hold_outs", outs, 0);
        pll_locked = 1'b0;
        cyc(10);
        chk("hold_lol_outs", outs, 0);
        pll_locked = 1'b1;
        user_rst   = 1'b0;
        wait_rel(k, leak, 3000);
        chk("hold_lol_release", k, 1283);
        chk("hold_lol_leak", leak, 0);

        run_cadence(480);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
